adc_spi_capture: RTL and testbench



---
 rtl/adc_spi_capture_pkg.sv | 33 +++
 rtl/adc_spi_capture_if.sv | 50 +++++
 rtl/adc_spi_capture_sclk_edge_gen.sv | 61 ++++++
 rtl/adc_spi_capture.sv | 212 +++++++++++++++++++++
 tb/tb_adc_spi_capture.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/adc_spi_capture_pkg.sv
// -----------------------------------------------------------------------------
// adc_pkg
// Shared definitions for the ADC SPI capture block: FSM state encoding,
// default timing constants and a small counter-width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package adc_pkg;

    // FSM state encoding
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_SHIFT = 3'd2;
    localparam state_t ST_DONE  = 3'd3;
    localparam state_t ST_QUIET = 3'd4;

    // Default timing, in clk_out cycles
    localparam int DEF_DATA_WIDTH      = 16;
    localparam int DEF_SCLK_HALF       = 2;
    localparam int DEF_CS_SETUP_CYCLES = 2;
    localparam int DEF_CS_HIGH_CYCLES  = 4;

    // Width of a counter that must hold values 0..n-1; never narrower than 1 bit
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            cnt_width = $clog2(n);
        end else begin
            cnt_width = 1;
        end
    endfunction

endpackage : adc_pkg

// File: rtl/adc_spi_capture_if.sv
// -----------------------------------------------------------------------------
// adc_spi_capture_if
// Bundles the request/strobe side toward the FIR filter and the serial pins
// toward the ADC.
//   sample_req      - single-cycle conversion request
//   adc_sdo         - ADC serial data, MSB first
//   adc_cs_n        - ADC chip select, active low
//   adc_sclk        - ADC serial clock, idles low
//   filter_data_out - last captured sample, held between conversions
//   filter_enable   - one-cycle strobe marking a new filter_data_out
//   busy            - conversion in progress (state != IDLE)
//   overrun         - sticky: a request arrived while busy
// Modports: slave = capture block, master = its environment.
// -----------------------------------------------------------------------------
interface adc_spi_capture_if #(
    parameter int DATA_WIDTH = 16
) ();

    logic                  sample_req;
    logic                  adc_sdo;
    logic                  adc_cs_n;
    logic                  adc_sclk;
    logic [DATA_WIDTH-1:0] filter_data_out;
    logic                  filter_enable;
    logic                  busy;
    logic                  overrun;

    modport slave (
        input  sample_req,
        input  adc_sdo,
        output adc_cs_n,
        output adc_sclk,
        output filter_data_out,
        output filter_enable,
        output busy,
        output overrun
    );

    modport master (
        output sample_req,
        output adc_sdo,
        input  adc_cs_n,
        input  adc_sclk,
        input  filter_data_out,
        input  filter_enable,
        input  busy,
        input  overrun
    );

endinterface : adc_spi_capture_if

// File: rtl/adc_spi_capture_sclk_edge_gen.sv
// -----------------------------------------------------------------------------
// sclk_edge_gen
// Divides clk_out down to the ADC serial clock. While enabled, sclk toggles
// every SCLK_HALF cycles starting from low. sclk_rise / sclk_fall are high in
// the cycle whose closing clk_out edge drives sclk high / low, so the parent
// can act on exactly that edge. When disabled the divider sits at low/idle.
//   clk_out   - system clock
//   reset     - synchronous, active-high
//   enable    - run the divider
//   sclk      - registered serial clock
//   sclk_rise - next edge drives sclk high
//   sclk_fall - next edge drives sclk low
// -----------------------------------------------------------------------------
module sclk_edge_gen
    import adc_pkg::*;
#(
    parameter int SCLK_HALF = DEF_SCLK_HALF
) (
    input  logic clk_out,
    input  logic reset,
    input  logic enable,
    output logic sclk,
    output logic sclk_rise,
    output logic sclk_fall
);

    localparam int               CNT_W    = cnt_width(SCLK_HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_HALF - 1);

    logic [CNT_W-1:0] div_cnt_r;
    logic             sclk_r;
    logic             wrap_s;

    // Half-period boundary detect and edge strobes
    always_comb begin
        wrap_s = 1'b0;
        if (enable && (div_cnt_r == CNT_LAST)) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
    end

    assign sclk_rise = wrap_s & ~sclk_r;
    assign sclk_fall = wrap_s &  sclk_r;
    assign sclk      = sclk_r;

    // Divide counter and sclk toggle register
    always_ff @(posedge clk_out) begin
        if (reset || !enable) begin
            div_cnt_r <= '0;
            sclk_r    <= 1'b0;
        end else if (wrap_s) begin
            div_cnt_r <= '0;
            sclk_r    <= ~sclk_r;
        end else begin
            div_cnt_r <= div_cnt_r + CNT_W'(1);
        end
    end

endmodule : sclk_edge_gen

// File: rtl/adc_spi_capture.sv
// -----------------------------------------------------------------------------
// adc_spi_capture
// Reads one DATA_WIDTH-bit sample MSB-first from a serial ADC per request and
// hands it to the FIR filter as a data/strobe pair.
//   clk_out - system clock, rising edge
//   reset   - synchronous, active-high
//   bus     - adc_spi_capture_if.slave (request, ADC pins, filter outputs)
// All outputs are registered. Output registers are loaded from the decoded
// next state, so cs_n/busy/filter_enable change on the same edge as the state.
// -----------------------------------------------------------------------------
module adc_spi_capture
    import adc_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int SCLK_HALF       = DEF_SCLK_HALF,
    parameter int CS_SETUP_CYCLES = DEF_CS_SETUP_CYCLES,
    parameter int CS_HIGH_CYCLES  = DEF_CS_HIGH_CYCLES
) (
    input  logic              clk_out,
    input  logic              reset,
    adc_spi_capture_if.slave  bus
);

    localparam int TMR_W = cnt_width((CS_SETUP_CYCLES > CS_HIGH_CYCLES) ?
                                     CS_SETUP_CYCLES : CS_HIGH_CYCLES);
    localparam int BIT_W = cnt_width(DATA_WIDTH);

    // Last timer value of SETUP, and of QUIET (QUIET is CS_HIGH_CYCLES-1 long)
    localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP_CYCLES - 1);
    localparam logic [TMR_W-1:0] QUIET_LAST = TMR_W'((CS_HIGH_CYCLES >= 2) ?
                                                     (CS_HIGH_CYCLES - 2) : 0);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_WIDTH - 1);

    state_t                state_r;
    state_t                next_state_s;
    logic [TMR_W-1:0]      timer_r;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;

    logic                  cs_n_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  fen_r;
    logic                  busy_r;
    logic                  overrun_r;

    logic                  cs_n_next_s;
    logic                  fen_next_s;
    logic                  busy_next_s;

    logic                  sclk_s;
    logic                  sclk_rise_s;
    logic                  sclk_fall_s;
    logic                  sclk_en_s;

    assign sclk_en_s = (state_r == ST_SHIFT);

    sclk_edge_gen #(
        .SCLK_HALF (SCLK_HALF)
    ) u_sclk_edge_gen (
        .clk_out   (clk_out),
        .reset     (reset),
        .enable    (sclk_en_s),
        .sclk      (sclk_s),
        .sclk_rise (sclk_rise_s),
        .sclk_fall (sclk_fall_s)
    );

    // FSM state register
    always_ff @(posedge clk_out) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.sample_req) begin
                    next_state_s = ST_SETUP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (timer_r == SETUP_LAST) begin
                    next_state_s = ST_SHIFT;
                end else begin
                    next_state_s = ST_SETUP;
                end
            end
            ST_SHIFT: begin
                // the final falling sclk edge closes the frame
                if (sclk_fall_s && (bit_cnt_r == BIT_LAST)) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                // DONE itself counts toward the cs_n high time
                if (CS_HIGH_CYCLES <= 1) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_QUIET;
                end
            end
            ST_QUIET: begin
                if (timer_r == QUIET_LAST) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_QUIET;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode from the state being entered
    always_comb begin
        cs_n_next_s = 1'b1;
        fen_next_s  = 1'b0;
        busy_next_s = 1'b0;
        case (next_state_s)
            ST_IDLE: begin
                cs_n_next_s = 1'b1;
                busy_next_s = 1'b0;
            end
            ST_SETUP, ST_SHIFT: begin
                cs_n_next_s = 1'b0;
                busy_next_s = 1'b1;
            end
            ST_DONE: begin
                cs_n_next_s = 1'b1;
                fen_next_s  = 1'b1;
                busy_next_s = 1'b1;
            end
            ST_QUIET: begin
                cs_n_next_s = 1'b1;
                busy_next_s = 1'b1;
            end
            default: begin
                cs_n_next_s = 1'b1;
                fen_next_s  = 1'b0;
                busy_next_s = 1'b0;
            end
        endcase
    end

    // Phase timer for SETUP and QUIET; restarts on every state change
    always_ff @(posedge clk_out) begin
        if (reset) begin
            timer_r <= '0;
        end else if (next_state_s != state_r) begin
            timer_r <= '0;
        end else if ((state_r == ST_SETUP) || (state_r == ST_QUIET)) begin
            timer_r <= timer_r + TMR_W'(1);
        end
    end

    // Falling-edge bit counter and MSB-first shift register
    always_ff @(posedge clk_out) begin
        if (reset) begin
            bit_cnt_r <= '0;
            shift_r   <= '0;
        end else begin
            if (next_state_s != ST_SHIFT) begin
                bit_cnt_r <= '0;
            end else if (sclk_fall_s) begin
                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            end
            if (sclk_rise_s) begin
                shift_r <= {shift_r[DATA_WIDTH-2:0], bus.adc_sdo};
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk_out) begin
        if (reset) begin
            cs_n_r    <= 1'b1;
            data_r    <= '0;
            fen_r     <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            cs_n_r <= cs_n_next_s;
            fen_r  <= fen_next_s;
            busy_r <= busy_next_s;
            if (fen_next_s) begin
                data_r <= shift_r;
            end
            // requests outside IDLE are dropped and flagged until reset
            if (bus.sample_req && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign bus.adc_cs_n        = cs_n_r;
    assign bus.adc_sclk        = sclk_s;
    assign bus.filter_data_out = data_r;
    assign bus.filter_enable   = fen_r;
    assign bus.busy            = busy_r;
    assign bus.overrun         = overrun_r;

endmodule : adc_spi_capture

// File: tb/tb_adc_spi_capture.sv
// -----------------------------------------------------------------------------
// tb_adc_spi_capture
// Directed bench for adc_spi_capture: one instance with default timing and
// one with SCLK_HALF=CS_SETUP_CYCLES=CS_HIGH_CYCLES=1. Each has a serial ADC
// model that presents the MSB when cs_n is low and advances one bit after
// every falling sclk edge.
// -----------------------------------------------------------------------------
module tb_adc_spi_capture;

    logic clk_out = 1'b0;
    logic reset   = 1'b1;

    always #5 clk_out = ~clk_out;

    adc_spi_capture_if #(.DATA_WIDTH(16)) if_m ();
    adc_spi_capture_if #(.DATA_WIDTH(16)) if_s ();

    adc_spi_capture #(
        .DATA_WIDTH      (16),
        .SCLK_HALF       (2),
        .CS_SETUP_CYCLES (2),
        .CS_HIGH_CYCLES  (4)
    ) u_dut_m (
        .clk_out (clk_out),
        .reset   (reset),
        .bus     (if_m)
    );

    adc_spi_capture #(
        .DATA_WIDTH      (16),
        .SCLK_HALF       (1),
        .CS_SETUP_CYCLES (1),
        .CS_HIGH_CYCLES  (1)
    ) u_dut_s (
        .clk_out (clk_out),
        .reset   (reset),
        .bus     (if_s)
    );

    // ADC models: bit index reloads while cs_n is high, steps after sclk falls
    logic [15:0] word_m = 16'h0000;
    logic [15:0] word_s = 16'h0000;
    logic [3:0]  idx_m  = 4'd15;
    logic [3:0]  idx_s  = 4'd15;
    logic        prev_sclk_m = 1'b0;
    logic        prev_sclk_s = 1'b0;

    assign if_m.adc_sdo = word_m[idx_m];
    assign if_s.adc_sdo = word_s[idx_s];

    // Mid-cycle ADC model update, away from the DUT sampling edge
    always @(negedge clk_out) begin
        if (if_m.adc_cs_n) idx_m <= 4'd15;
        else if (prev_sclk_m && !if_m.adc_sclk) idx_m <= idx_m - 4'd1;
        prev_sclk_m <= if_m.adc_sclk;
        if (if_s.adc_cs_n) idx_s <= 4'd15;
        else if (prev_sclk_s && !if_s.adc_sclk) idx_s <= idx_s - 4'd1;
        prev_sclk_s <= if_s.adc_sclk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_out);
        #1;
    endtask

    // One default-timing conversion; optional extra request at edge E0+extra_at
    task automatic conv_m(input logic [15:0] word, input int extra_at, input string tag);
        int   rises;
        int   strobes;
        logic prev;
        word_m = word;
        if_m.sample_req = 1'b1;
        tick();                               // edge E0
        if_m.sample_req = 1'b0;
        check($sformatf("%s_csn_low", tag), {31'd0, if_m.adc_cs_n}, 32'd0);
        check($sformatf("%s_busy_hi", tag), {31'd0, if_m.busy}, 32'd1);
        rises   = 0;
        strobes = 0;
        prev    = if_m.adc_sclk;
        for (int i = 1; i <= 65; i++) begin
            if_m.sample_req = (i == extra_at) ? 1'b1 : 1'b0;
            tick();                           // edge E0+i
            if (!prev && if_m.adc_sclk) rises++;
            prev = if_m.adc_sclk;
            if (if_m.filter_enable) strobes++;
        end
        if_m.sample_req = 1'b0;
        check($sformatf("%s_early_strobe", tag), strobes, 32'd0);
        tick();                               // edge E0+66
        check($sformatf("%s_fen_66", tag), {31'd0, if_m.filter_enable}, 32'd1);
        check($sformatf("%s_data", tag), {16'd0, if_m.filter_data_out}, {16'd0, word});
        check($sformatf("%s_csn_66", tag), {31'd0, if_m.adc_cs_n}, 32'd1);
        check($sformatf("%s_rises", tag), rises, 32'd16);
        tick();                               // edge E0+67
        check($sformatf("%s_fen_67", tag), {31'd0, if_m.filter_enable}, 32'd0);
        check($sformatf("%s_hold", tag), {16'd0, if_m.filter_data_out}, {16'd0, word});
        tick();
        tick();                               // edge E0+69
        check($sformatf("%s_busy_69", tag), {31'd0, if_m.busy}, 32'd1);
        tick();                               // edge E0+70
        check($sformatf("%s_busy_70", tag), {31'd0, if_m.busy}, 32'd0);
    endtask

    initial begin
        int   cnt_a;
        int   cnt_b;
        logic prev;
        if_m.sample_req = 1'b0;
        if_s.sample_req = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        check("rst_csn",  {31'd0, if_m.adc_cs_n}, 32'd1);
        check("rst_sclk", {31'd0, if_m.adc_sclk}, 32'd0);
        check("rst_data", {16'd0, if_m.filter_data_out}, 32'd0);
        check("rst_fen",  {31'd0, if_m.filter_enable}, 32'd0);
        check("rst_busy", {31'd0, if_m.busy}, 32'd0);
        check("rst_ovr",  {31'd0, if_m.overrun}, 32'd0);
        reset = 1'b0;
        tick();

        // single capture
        conv_m(16'hA5C3, 0, "single");
        check("single_ovr", {31'd0, if_m.overrun}, 32'd0);

        // back-to-back: second request in the first cycle busy is low
        conv_m(16'hFFFF, 0, "b2b_1");
        conv_m(16'h0001, 0, "b2b_2");
        check("b2b_ovr", {31'd0, if_m.overrun}, 32'd0);

        // overrun: extra request at E0+30 is dropped
        conv_m(16'h3C96, 30, "ovr");
        check("ovr_set", {31'd0, if_m.overrun}, 32'd1);
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (if_m.filter_enable) cnt_a++;
            if (if_m.busy) cnt_b++;
        end
        check("ovr_no_strobe", cnt_a, 32'd0);
        check("ovr_no_busy", cnt_b, 32'd0);
        check("ovr_sticky", {31'd0, if_m.overrun}, 32'd1);
        check("ovr_data", {16'd0, if_m.filter_data_out}, 32'h3C96);

        // reset in the middle of the shift phase
        word_m = 16'h1234;
        if_m.sample_req = 1'b1;
        tick();                               // edge E0
        if_m.sample_req = 1'b0;
        repeat (39) tick();                   // edge E0+39
        check("mid_busy", {31'd0, if_m.busy}, 32'd1);
        reset = 1'b1;
        tick();                               // edge E0+40
        reset = 1'b0;
        check("mid_csn",  {31'd0, if_m.adc_cs_n}, 32'd1);
        check("mid_sclk", {31'd0, if_m.adc_sclk}, 32'd0);
        check("mid_busy0", {31'd0, if_m.busy}, 32'd0);
        check("mid_data", {16'd0, if_m.filter_data_out}, 32'd0);
        check("mid_ovr",  {31'd0, if_m.overrun}, 32'd0);
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (if_m.filter_enable) cnt_a++;
            if (!if_m.adc_cs_n) cnt_b++;
        end
        check("mid_no_strobe", cnt_a, 32'd0);
        check("mid_cs_idle", cnt_b, 32'd0);

        // minimum timing instance
        word_s = 16'h8001;
        if_s.sample_req = 1'b1;
        tick();                               // edge E0
        if_s.sample_req = 1'b0;
        check("sw_csn_low", {31'd0, if_s.adc_cs_n}, 32'd0);
        cnt_a = 0;
        cnt_b = 0;
        prev  = if_s.adc_sclk;
        for (int i = 1; i <= 32; i++) begin
            tick();                           // edge E0+i
            if (!prev && if_s.adc_sclk) cnt_a++;
            prev = if_s.adc_sclk;
            if (if_s.filter_enable) cnt_b++;
            if (i == 1) check("sw_sclk_1", {31'd0, if_s.adc_sclk}, 32'd0);
            if (i == 2) check("sw_sclk_2", {31'd0, if_s.adc_sclk}, 32'd1);
            if (i == 3) check("sw_sclk_3", {31'd0, if_s.adc_sclk}, 32'd0);
        end
        check("sw_rises", cnt_a, 32'd16);
        check("sw_early_strobe", cnt_b, 32'd0);
        tick();                               // edge E0+33
        check("sw_fen_33", {31'd0, if_s.filter_enable}, 32'd1);
        check("sw_data", {16'd0, if_s.filter_data_out}, 32'h8001);
        check("sw_busy_33", {31'd0, if_s.busy}, 32'd1);
        tick();                               // edge E0+34
        check("sw_fen_34", {31'd0, if_s.filter_enable}, 32'd0);
        check("sw_busy_34", {31'd0, if_s.busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_adc_spi_capture
